// File: rtl/systolic_input_feeder.sv
// Buffers activation vectors in a small FIFO and skews them onto the array rows; lane r lags lane 0 by r cycles.
// After a vector marked last, DRAIN injects bubbles until the skew has flushed, then done pulses for one cycle.
module systolic_input_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int ROWS       = 4,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] in_data,
  input  logic                       in_last,
  output logic [ROWS*DATA_WIDTH-1:0] row_data,
  output logic [ROWS-1:0]            row_valid,
  output logic                       busy,
  output logic                       done
);
  localparam int VW  = ROWS * DATA_WIDTH;
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int DCW = $clog2(ROWS);
  localparam logic [CW-1:0]  DEPTH_C    = CW'(DEPTH);
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(ROWS - 1);
  localparam logic [DCW-1:0] DRAIN_ONE  = DCW'(1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [VW-1:0]    mem_dat_q [DEPTH];
  logic             mem_last_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DCW-1:0]   drain_cnt_q, drain_cnt_d;
  logic             done_q, done_d;
  logic             push, pop;
  logic [VW-1:0]    pop_dat;
  logic             pop_last;

  assign in_ready = (count_q < DEPTH_C);
  assign push     = in_valid && in_ready;
  assign pop_dat  = mem_dat_q[rd_ptr_q];
  assign pop_last = mem_last_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_dat_q[wr_ptr_q]  <= in_data;
      mem_last_q[wr_ptr_q] <= in_last;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      drain_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      drain_cnt_q <= drain_cnt_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, STREAM: if (count_q != '0) state_d = pop_last ? DRAIN : STREAM;
      DRAIN:        if (drain_cnt_q == DRAIN_ONE) state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  always_comb begin
    pop         = 1'b0;
    drain_cnt_d = drain_cnt_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE, STREAM: begin
        pop = (count_q != '0);
        if (pop && pop_last) drain_cnt_d = DRAIN_LOAD;
      end
      DRAIN: begin
        drain_cnt_d = drain_cnt_q - DRAIN_ONE;
        done_d      = (drain_cnt_q == DRAIN_ONE);
      end
      default: ;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;

  // Lane r is a chain of r+1 registers; stage 0 of every lane loads on the pop edge.
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [DATA_WIDTH-1:0] dat_q [r+1];
    logic [DATA_WIDTH-1:0] dat_d [r+1];
    logic [r:0]            vld_q, vld_d;

    always_comb begin
      dat_d[0] = pop ? pop_dat[r*DATA_WIDTH +: DATA_WIDTH] : '0;
      vld_d[0] = pop;
      for (int k = 1; k <= r; k++) begin
        dat_d[k] = dat_q[k-1];
        vld_d[k] = vld_q[k-1];
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int k = 0; k <= r; k++) dat_q[k] <= '0;
        vld_q <= '0;
      end else begin
        for (int k = 0; k <= r; k++) dat_q[k] <= dat_d[k];
        vld_q <= vld_d;
      end
    end

    assign row_data[r*DATA_WIDTH +: DATA_WIDTH] = dat_q[r];
    assign row_valid[r]                         = vld_q[r];
  end

endmodule

// File: tb/tb_systolic_input_feeder.sv
// Drives directed and random vector streams into the feeder and compares every cycle against
// a schedule-based model: a popped vector's element r is due r cycles after its pop edge.
module tb_systolic_input_feeder;
  localparam int DW    = 32;
  localparam int ROWS  = 4;
  localparam int DEPTH = 4;
  localparam int VW    = ROWS * DW;
  localparam int SW    = 64;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_last = 1'b0;
  logic [VW-1:0]   in_data = '0;
  logic            in_ready;
  logic [VW-1:0]   row_data;
  logic [ROWS-1:0] row_valid;
  logic            busy;
  logic            done;

  always #5 clk = ~clk;

  systolic_input_feeder #(.DATA_WIDTH(DW), .ROWS(ROWS), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .row_data(row_data),
    .row_valid(row_valid), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [VW-1:0] d;
    logic          last;
  } vec_t;

  vec_t            mq[$];
  int              cyc = 0;
  int              done_edge = -1;
  int              checks = 0;
  int              failures = 0;
  bit              draining = 0;
  bit              m_busy = 0;
  logic [DW-1:0]   sch_dat [SW][ROWS];
  bit              sch_vld [SW][ROWS];
  logic [VW-1:0]   exp_rd;
  logic [ROWS-1:0] exp_rv;
  logic            exp_busy, exp_done, exp_ready, obs_ready;

  function automatic logic [VW-1:0] mkvec(input logic [DW-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [VW-1:0] rndvec();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_clear();
    mq.delete();
    draining  = 0;
    m_busy    = 0;
    done_edge = -1;
    for (int s = 0; s < SW; s++)
      for (int r = 0; r < ROWS; r++) begin
        sch_vld[s][r] = 0;
        sch_dat[s][r] = '0;
      end
    exp_rd = '0; exp_rv = '0; exp_busy = 0; exp_done = 0;
  endtask

  // One clock: drive inputs, sample in_ready before the edge, advance the model, return at edge+1.
  task automatic tick(input bit v, input logic [VW-1:0] d, input bit l);
    vec_t nv;
    bit   full;
    in_valid = v; in_data = d; in_last = l;
    #1;
    obs_ready = in_ready;
    exp_ready = (mq.size() < DEPTH);
    @(posedge clk);
    cyc++;
    full     = (mq.size() >= DEPTH);
    exp_done = 0;
    if (draining) begin
      if (cyc == done_edge) begin
        draining = 0; m_busy = 0; exp_done = 1;
      end
    end else if (mq.size() > 0) begin
      nv = mq.pop_front();
      m_busy = 1;
      for (int r = 0; r < ROWS; r++) begin
        sch_dat[(cyc + r) % SW][r] = nv.d[r*DW +: DW];
        sch_vld[(cyc + r) % SW][r] = 1;
      end
      if (nv.last) begin
        draining  = 1;
        done_edge = cyc + ROWS - 1;
      end
    end
    if (v && !full) begin
      nv.d = d; nv.last = l;
      mq.push_back(nv);
    end
    for (int r = 0; r < ROWS; r++) begin
      exp_rv[r]          = sch_vld[cyc % SW][r];
      exp_rd[r*DW +: DW] = sch_vld[cyc % SW][r] ? sch_dat[cyc % SW][r] : '0;
      sch_vld[cyc % SW][r] = 0;
    end
    exp_busy = m_busy;
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (row_valid !== '0 || row_data !== '0 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state vld=%b busy=%b done=%b rdy=%b required vld=0 busy=0 done=0 rdy=1", row_valid, busy, done, in_ready);
    end
    in_valid = 1; in_last = 1; in_data = rndvec();
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (row_valid !== '0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_push_ignored vld=%b busy=%b rdy=%b required 0/0/1", row_valid, busy, in_ready);
    end
    reset = 1'b1;
    in_valid = 0;
    model_clear();
    for (int k = 0; k < 3; k++) begin
      tick(0, '0, 0);
      checks++;
      if (obs_ready !== exp_ready || row_valid !== exp_rv || row_data !== exp_rd || busy !== exp_busy || done !== exp_done) begin
        failures++;
        $display("FAIL post_reset cyc=%0d rdy=%b/%b vld=%b/%b busy=%b/%b done=%b/%b", cyc, obs_ready, exp_ready, row_valid, exp_rv, busy, exp_busy, done, exp_done);
      end
    end
  endtask

  task automatic test_single();
    for (int k = 0; k < 7; k++) begin
      tick(k == 0, mkvec(1, 2, 3, 4), 1);
      checks++;
      if (obs_ready !== exp_ready || row_valid !== exp_rv || row_data !== exp_rd || busy !== exp_busy || done !== exp_done) begin
        failures++;
        $display("FAIL single cyc=%0d rdy=%b/%b vld=%b/%b busy=%b/%b done=%b/%b data=%h/%h", cyc, obs_ready, exp_ready, row_valid, exp_rv, busy, exp_busy, done, exp_done, row_data, exp_rd);
      end
      if (k == 1) begin
        checks++;
        if (row_valid !== 4'b0001 || row_data[31:0] !== 32'd1) begin
          failures++;
          $display("FAIL single_lane0 vld=%b lane0=%0d required vld=0001 lane0=1", row_valid, row_data[31:0]);
        end
      end
      if (k == 4) begin
        checks++;
        if (row_valid !== 4'b1000 || row_data[127:96] !== 32'd4 || done !== 1'b1 || busy !== 1'b0) begin
          failures++;
          $display("FAIL single_lane3 vld=%b lane3=%0d done=%b busy=%b required 1000/4/1/0", row_valid, row_data[127:96], done, busy);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int n0 = 0, n3 = 0, ndone = 0, done_at = -1;
    for (int k = 0; k < 10; k++) begin
      tick(k < 3, rndvec(), k == 2);
      checks++;
      if (obs_ready !== exp_ready || row_valid !== exp_rv || row_data !== exp_rd || busy !== exp_busy || done !== exp_done) begin
        failures++;
        $display("FAIL b2b cyc=%0d rdy=%b/%b vld=%b/%b busy=%b/%b done=%b/%b data=%h/%h", cyc, obs_ready, exp_ready, row_valid, exp_rv, busy, exp_busy, done, exp_done, row_data, exp_rd);
      end
      n0 += int'(row_valid[0]);
      n3 += int'(row_valid[3]);
      if (done) begin ndone++; done_at = k; end
    end
    checks++;
    if (n0 != 3 || n3 != 3 || ndone != 1 || done_at != 6) begin
      failures++;
      $display("FAIL b2b_counts lane0=%0d lane3=%0d dones=%0d done_at=%0d required 3/3/1/6", n0, n3, ndone, done_at);
    end
  endtask

  task automatic test_bubble();
    logic [3:0] pat = '0;
    bit         busy_all = 1;
    for (int k = 0; k < 10; k++) begin
      tick(k == 0 || k == 3, rndvec(), k == 3);
      checks++;
      if (obs_ready !== exp_ready || row_valid !== exp_rv || row_data !== exp_rd || busy !== exp_busy || done !== exp_done) begin
        failures++;
        $display("FAIL bubble cyc=%0d rdy=%b/%b vld=%b/%b busy=%b/%b done=%b/%b data=%h/%h", cyc, obs_ready, exp_ready, row_valid, exp_rv, busy, exp_busy, done, exp_done, row_data, exp_rd);
      end
      if (k >= 1 && k <= 4) begin
        pat = {pat[2:0], row_valid[0]};
        if (busy !== 1'b1) busy_all = 0;
      end
    end
    checks++;
    if (pat !== 4'b1001 || !busy_all) begin
      failures++;
      $display("FAIL bubble_pattern lane0=%b busy_held=%0d required 1001/1", pat, busy_all);
    end
  endtask

  task automatic test_full();
    bit saw_full = 0, first_done = 0, popped_after = 0;
    int max_q = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == 0)       tick(1, rndvec(), 1);
      else if (k < 16)  tick(1, rndvec(), $urandom_range(0, 2) == 0);
      else              tick(0, '0, 0);
      checks++;
      if (obs_ready !== exp_ready || row_valid !== exp_rv || row_data !== exp_rd || busy !== exp_busy || done !== exp_done) begin
        failures++;
        $display("FAIL full cyc=%0d rdy=%b/%b vld=%b/%b busy=%b/%b done=%b/%b data=%h/%h", cyc, obs_ready, exp_ready, row_valid, exp_rv, busy, exp_busy, done, exp_done, row_data, exp_rd);
      end
      if (obs_ready === 1'b0) saw_full = 1;
      if (mq.size() > max_q) max_q = mq.size();
      if (first_done == 1 && !popped_after) popped_after = (row_valid[0] === 1'b1) ? 1 : 0;
      if (first_done == 1 && k > 0) first_done = 0;
      if (done === 1'b1 && !popped_after && max_q > 0 && k == 4) first_done = 1;
    end
    checks++;
    if (!saw_full || max_q != DEPTH || !popped_after) begin
      failures++;
      $display("FAIL full_flags saw_not_ready=%0d max_count=%0d pop_after_done=%0d required 1/%0d/1", saw_full, max_q, popped_after, DEPTH);
    end
  endtask

  task automatic test_async_reset();
    int ndone = 0;
    tick(1, rndvec(), 1);
    tick(1, rndvec(), 0);
    tick(1, rndvec(), 0);
    checks++;
    if (obs_ready !== exp_ready || row_valid !== exp_rv || row_data !== exp_rd || busy !== exp_busy || done !== exp_done || mq.size() != 2) begin
      failures++;
      $display("FAIL arst_setup cyc=%0d vld=%b/%b busy=%b/%b queued=%0d required 2", cyc, row_valid, exp_rv, busy, exp_busy, mq.size());
    end
    in_valid = 0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (row_valid !== '0 || row_data !== '0 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL arst_immediate vld=%b busy=%b done=%b rdy=%b required 0/0/0/1", row_valid, busy, done, in_ready);
    end
    model_clear();
    in_valid = 1; in_last = 1; in_data = rndvec();
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); cyc++; #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || row_valid !== '0) begin
        failures++;
        $display("FAIL arst_held done=%b busy=%b vld=%b required 0/0/0", done, busy, row_valid);
      end
    end
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick(k == 0, mkvec(32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003, 32'hA5A5_0004), 1);
      checks++;
      if (obs_ready !== exp_ready || row_valid !== exp_rv || row_data !== exp_rd || busy !== exp_busy || done !== exp_done) begin
        failures++;
        $display("FAIL arst_resume cyc=%0d rdy=%b/%b vld=%b/%b busy=%b/%b done=%b/%b data=%h/%h", cyc, obs_ready, exp_ready, row_valid, exp_rv, busy, exp_busy, done, exp_done, row_data, exp_rd);
      end
      ndone += int'(done);
    end
    checks++;
    if (ndone != 1) begin
      failures++;
      $display("FAIL arst_done_count dones=%0d required 1", ndone);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 260; k++) begin
      if (k < 230) tick($urandom_range(0, 3) != 0, rndvec(), $urandom_range(0, 4) == 0);
      else         tick(0, '0, 0);
      checks++;
      if (obs_ready !== exp_ready || row_valid !== exp_rv || row_data !== exp_rd || busy !== exp_busy || done !== exp_done) begin
        failures++;
        $display("FAIL random cyc=%0d rdy=%b/%b vld=%b/%b busy=%b/%b done=%b/%b data=%h/%h", cyc, obs_ready, exp_ready, row_valid, exp_rv, busy, exp_busy, done, exp_done, row_data, exp_rd);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    test_reset();
    test_single();
    test_back_to_back();
    test_bubble();
    test_full();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
